search_launcher: RTL and testbench

Front-end stage directly upstream of `accelerator_fsm`. It accepts one read-search request through a valid/ready handshake and clears the per-search register files. It then writes the seed recursion entry into `regfile_InexRecur` and the initial state word into `regfile_state`. Finally it raises `is_start` and supervises the search until done or timeout, returning a status/cycle-count response.

---
 rtl/accel_pkg.sv | 38 +++
 rtl/launch_timer.sv | 21 ++
 rtl/search_launcher.sv | 112 +++++++++++
 tb/tb_search_launcher.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: shared launcher state/status encodings and regfile word layouts
package accel_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WRITE,
    ST_SETTLE,
    ST_RUN,
    ST_RESP
  } launch_state_e;
  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_TIMEOUT = 2'b01,
    STAT_BADREQ  = 2'b10
  } launch_status_e;
  localparam int IR_W       = 32;
  localparam int IR_FIELD_W = 8;
  localparam int IR_I_LSB   = 24;
  localparam int IR_Z_LSB   = 16;
  localparam int IR_K_LSB   = 8;
  localparam int IR_L_LSB   = 0;
  localparam int STATE_W    = 18;
  localparam logic [STATE_W-1:0] INIT_STATE_WORD = 18'h0C000;
  function automatic logic [IR_W-1:0] pack_ir(
    input logic [IR_FIELD_W-1:0] i,
    input logic [IR_FIELD_W-1:0] z,
    input logic [IR_FIELD_W-1:0] k,
    input logic [IR_FIELD_W-1:0] l
  );
    logic [IR_W-1:0] w;
    w = '0;
    w[IR_I_LSB +: IR_FIELD_W] = i;
    w[IR_Z_LSB +: IR_FIELD_W] = z;
    w[IR_K_LSB +: IR_FIELD_W] = k;
    w[IR_L_LSB +: IR_FIELD_W] = l;
    return w;
  endfunction
endpackage

// File: rtl/launch_timer.sv
// launch_timer: 16-bit saturating RUN-cycle counter with terminal-count flag
module launch_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] cnt_o,
  output logic        tc_o
);
  localparam logic [15:0] TC = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  // count enabled cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == TC;
endmodule

// File: rtl/search_launcher.sv
// search_launcher: accepts a read-search request, seeds the regfiles, runs and supervises the search
module search_launcher
  import accel_pkg::*;
#(
  parameter int          MAX_READ_LEN   = 64,
  parameter int          MAX_DIFF       = 3,
  parameter logic [17:0] INIT_STATE     = INIT_STATE_WORD,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_read_len,
  input  logic [7:0]  req_max_diff,
  input  logic [7:0]  req_k,
  input  logic [7:0]  req_l,
  output logic        regfile_clr_o,
  output logic        we_InexRecur_o,
  output logic [31:0] w_data_InexRecur_o,
  output logic        we_state_o,
  output logic [17:0] w_data_state_o,
  output logic        is_start_o,
  input  logic        search_done_i,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_status,
  output logic [15:0] resp_cycles
);
  localparam logic [7:0] MAX_LEN8  = 8'(MAX_READ_LEN);
  localparam logic [7:0] MAX_DIFF8 = 8'(MAX_DIFF);
  launch_state_e  state_q;
  launch_status_e status_q;
  logic [31:0]    seed_q;
  logic           bad_req, tmr_clr, tmr_en, tmr_tc;
  assign bad_req = req_read_len == 8'd0 || req_read_len > MAX_LEN8 ||
                   req_max_diff > MAX_DIFF8 || req_k > req_l;
  assign tmr_clr = state_q != ST_RUN && state_q != ST_RESP;
  assign tmr_en  = state_q == ST_RUN;
  assign resp_status = status_q;
  launch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .cnt_o (resp_cycles),
    .tc_o  (tmr_tc)
  );
  // launcher FSM; every output is registered and set on the edge entering its state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      status_q           <= STAT_OK;
      seed_q             <= '0;
      req_ready          <= 1'b1;
      regfile_clr_o      <= 1'b0;
      we_InexRecur_o     <= 1'b0;
      we_state_o         <= 1'b0;
      w_data_InexRecur_o <= '0;
      w_data_state_o     <= '0;
      is_start_o         <= 1'b0;
      resp_valid         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid && req_ready) begin
          req_ready <= 1'b0;
          seed_q    <= pack_ir(req_read_len - 8'd1, req_max_diff, req_k, req_l);
          if (bad_req) begin
            state_q    <= ST_RESP;
            status_q   <= STAT_BADREQ;
            resp_valid <= 1'b1;
          end else begin
            state_q       <= ST_CLEAR;
            regfile_clr_o <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q            <= ST_WRITE;
          regfile_clr_o      <= 1'b0;
          we_InexRecur_o     <= 1'b1;
          we_state_o         <= 1'b1;
          w_data_InexRecur_o <= seed_q;
          w_data_state_o     <= INIT_STATE;
        end
        ST_WRITE: begin
          state_q            <= ST_SETTLE;
          we_InexRecur_o     <= 1'b0;
          we_state_o         <= 1'b0;
          w_data_InexRecur_o <= '0;
          w_data_state_o     <= '0;
        end
        ST_SETTLE: begin
          state_q    <= ST_RUN;
          is_start_o <= 1'b1;
        end
        ST_RUN: if (search_done_i || tmr_tc) begin
          state_q    <= ST_RESP;
          is_start_o <= 1'b0;
          resp_valid <= 1'b1;
          status_q   <= search_done_i ? STAT_OK : STAT_TIMEOUT;
        end
        ST_RESP: if (resp_ready) begin
          state_q    <= ST_IDLE;
          status_q   <= STAT_OK;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_search_launcher.sv
// tb_search_launcher: scoreboard bench for search_launcher with a short timeout
module tb_search_launcher;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_read_len = '0, req_max_diff = '0, req_k = '0, req_l = '0;
  logic        regfile_clr_o, we_InexRecur_o, we_state_o, is_start_o;
  logic [31:0] w_data_InexRecur_o;
  logic [17:0] w_data_state_o;
  logic        search_done_i = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_status;
  logic [15:0] resp_cycles;
  int          n_run = 0, n_fail = 0;
  logic [17:0] sb[$];
  search_launcher #(
    .MAX_READ_LEN(64), .MAX_DIFF(3), .INIT_STATE(18'h0C000), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read_len(req_read_len), .req_max_diff(req_max_diff), .req_k(req_k), .req_l(req_l),
    .regfile_clr_o(regfile_clr_o),
    .we_InexRecur_o(we_InexRecur_o), .w_data_InexRecur_o(w_data_InexRecur_o),
    .we_state_o(we_state_o), .w_data_state_o(w_data_state_o),
    .is_start_o(is_start_o), .search_done_i(search_done_i),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_cycles(resp_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_enables"}, {28'd0, regfile_clr_o, we_InexRecur_o, we_state_o, is_start_o}, 32'd0);
    chk({tag, "_wdata_ir"}, w_data_InexRecur_o, 32'd0);
    chk({tag, "_wdata_st"}, 32'(w_data_state_o), 32'd0);
    chk({tag, "_resp"}, {13'd0, resp_valid, resp_status, resp_cycles}, 32'd0);
  endtask
  task automatic run_req(input logic [7:0] len, input logic [7:0] z, input logic [7:0] k,
                         input logic [7:0] l, input int done_at, input int hold, input bit ghost);
    logic bad, ok;
    logic [1:0] es;
    logic [15:0] ec;
    logic [17:0] e;
    logic [31:0] wd;
    logic [17:0] sd;
    int clr_n, we_n, st_n, rk;
    bad = len == 8'd0 || len > 8'd64 || z > 8'd3 || k > l;
    ok  = done_at > 0 && done_at <= TO;
    es  = bad ? 2'b10 : ok ? 2'b00 : 2'b01;
    ec  = bad ? 16'd0 : ok ? 16'(done_at) : 16'(TO);
    sb.push_back({es, ec});
    clr_n = 0; we_n = 0; st_n = 0; rk = 0; wd = '0; sd = '0;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_read_len = len; req_max_diff = z; req_k = k; req_l = l; req_valid = 1'b1;
    for (int c = 1; c <= 300 && rk == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      search_done_i = 1'b0;
      clr_n += int'(regfile_clr_o);
      if (we_InexRecur_o) begin
        we_n++;
        wd = w_data_InexRecur_o;
        sd = w_data_state_o;
        chk("we_state_pair", 32'(we_state_o), 32'd1);
      end
      if (is_start_o) st_n++;
      if (c == 2) chk("write_at_t2", 32'(we_InexRecur_o), 32'(!bad));
      if (c == 3) chk("wdata_zero_settle", w_data_InexRecur_o | 32'(w_data_state_o), 32'd0);
      if (c == 4) chk("run_at_t4", 32'(is_start_o), 32'(!bad));
      if (ghost && c == 3) search_done_i = 1'b1;
      if (done_at > 0 && c == 3 + done_at) search_done_i = 1'b1;
      if (resp_valid) rk = c;
    end
    search_done_i = 1'b0;
    chk("resp_latency", 32'(rk), bad ? 32'd1 : 32'(4 + int'(ec)));
    chk("clr_pulses", 32'(clr_n), bad ? 32'd0 : 32'd1);
    chk("write_count", 32'(we_n), bad ? 32'd0 : 32'd1);
    chk("start_cycles", 32'(st_n), 32'(ec));
    if (!bad) begin
      chk("ir_seed", wd, {len - 8'd1, z, k, l});
      chk("state_seed", 32'(sd), 32'h0C000);
    end
    e = sb.size() > 0 ? sb.pop_front() : 18'h3FFFF;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_status", 32'(resp_status), 32'(e[17:16]));
      chk("hold_cycles", 32'(resp_cycles), 32'(e[15:0]));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    chk("resp_status", 32'(resp_status), 32'(e[17:16]));
    chk("resp_cycles", 32'(resp_cycles), 32'(e[15:0]));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset_released");
    search_done_i = 1'b1;
    @(negedge clk);
    search_done_i = 1'b0;
    chk_idle_outputs("ghost_idle");
    run_req(8'd3, 8'd1, 8'd0, 8'd6, 10, 0, 1'b1);
    run_req(8'd0, 8'd1, 8'd0, 8'd6, 5, 0, 1'b0);
    run_req(8'd3, 8'd4, 8'd0, 8'd6, 5, 0, 1'b0);
    run_req(8'd65, 8'd0, 8'd0, 8'd0, 5, 0, 1'b0);
    run_req(8'd3, 8'd0, 8'd7, 8'd6, 5, 0, 1'b0);
    run_req(8'd64, 8'd3, 8'd5, 8'd5, 1, 0, 1'b0);
    run_req(8'd1, 8'd0, 8'd0, 8'd255, TO, 0, 1'b0);
    run_req(8'd5, 8'd2, 8'd1, 8'd9, 0, 5, 1'b1);
    @(negedge clk);
    req_read_len = 8'd4; req_max_diff = 8'd2; req_k = 8'd3; req_l = 8'd8; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_running", 32'(is_start_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("mid_run_reset");
    run_req(8'd4, 8'd2, 8'd3, 8'd8, 7, 2, 1'b0);
    for (int r = 0; r < 6; r++)
      run_req(8'($urandom_range(0, 70)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 10)),
              8'($urandom_range(0, 10)), int'($urandom_range(0, 18)), int'($urandom_range(0, 3)), 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
